// File: rtl/frame_gen_pkg.sv
// frame_gen_pkg: shared state encoding, default geometry and beat math
// for the frame stream scheduler.
package frame_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    STREAM,
    GAP
  } state_t;

  localparam int DEF_WIDTH     = 1920;
  localparam int DEF_HEIGHT    = 1080;
  localparam int DEF_NUMPLANES = 3;

  function automatic int beatsPerLine(
    input int width,
    input int planes,
    input int bytes
  );
    return (width * planes) / bytes;
  endfunction

endpackage

// File: rtl/frame_stream_scheduler_if.sv
// frame_stream_scheduler_if: AXI4-Stream video beat bundle with
// SOF (tuser) and EOL (tlast) sidebands.
interface frame_stream_scheduler_if #(
  parameter int DW = 8
) ();

  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tuser;
  logic          tlast;

  modport master (
    output tdata,
    output tvalid,
    output tuser,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tuser,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/frame_stream_scheduler_axis_out_reg.sv
// axis_out_reg: single-entry output register holding {tdata, tuser, tlast}
// with a valid/ready handshake on both sides.
module axis_out_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inValid,
  input  logic [DW-1:0] inData,
  input  logic          inUser,
  input  logic          inLast,
  output logic          inReady,
  frame_stream_scheduler_if.master m
);

  assign inReady = !m.tvalid || m.tready;

  // Payload is only rewritten on a load, so it holds during stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      m.tvalid <= 1'b0;
      m.tdata  <= '0;
      m.tuser  <= 1'b0;
      m.tlast  <= 1'b0;
    end else if (inValid && inReady) begin
      m.tvalid <= 1'b1;
      m.tdata  <= inData;
      m.tuser  <= inUser;
      m.tlast  <= inLast;
    end else if (m.tready) begin
      m.tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_stream_scheduler.sv
// frame_stream_scheduler: arms the pattern source per frame, emits SOF/EOL
// marked AXI4-Stream beats. Define FRAME_SCHED_STATS_EN for stat counters.
module frame_stream_scheduler
  import frame_gen_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int NUMPLANES  = DEF_NUMPLANES,
  parameter int DATA_BYTES = 1,
  parameter int FRAMES_W   = 16,
  parameter int GAP_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_start,
  input  logic                    cfg_stop,
  input  logic [FRAMES_W-1:0]     cfg_num_frames,
  input  logic [GAP_W-1:0]        cfg_gap_cycles,
  input  logic [DATA_BYTES*8-1:0] src_data,
  input  logic                    src_valid,
  output logic                    src_ready,
  output logic                    src_restart,
  frame_stream_scheduler_if.master m_axis,
  output logic                    busy,
  output logic                    frame_done,
  output logic [31:0]             stat_frames,
  output logic [31:0]             stat_stalls
);

  localparam int BPL =
    beatsPerLine(WIDTH, NUMPLANES, DATA_BYTES);
  localparam int BW = (BPL > 1) ? $clog2(BPL) : 1;
  localparam int LW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BPL - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(HEIGHT - 1);

  state_t              state;
  logic [BW-1:0]       beat;
  logic [LW-1:0]       line;
  logic [FRAMES_W-1:0] frameCnt;
  logic [FRAMES_W-1:0] numFrames;
  logic [FRAMES_W-1:0] frameNext;
  logic [GAP_W-1:0]    gapLen;
  logic [GAP_W-1:0]    gapCnt;
  logic                stopPending;
  logic                draining;
  logic                frameDone;
  logic                regReady;
  logic                accept;
  logic                lastBeat;
  logic                lastLine;
  logic                frameEnd;
  logic                runDone;
  logic                stopNow;
  logic                sofBeat;

  assign src_ready   = (state == STREAM) && !draining && regReady;
  assign src_restart = (state == ARM);
  assign accept      = src_ready && src_valid;
  assign lastBeat    = (beat == BEAT_LAST);
  assign lastLine    = (line == LINE_LAST);
  assign frameEnd    = accept && lastBeat && lastLine;
  assign sofBeat     = (line == '0) && (beat == '0);
  assign frameNext   = frameCnt + 1'b1;
  assign runDone     = (numFrames != '0) && (frameNext == numFrames);
  assign stopNow     = stopPending || cfg_stop;
  assign busy        = (state != IDLE) || m_axis.tvalid;
  assign frame_done  = frameDone;

  axis_out_reg #(
    .DW(DATA_BYTES * 8)
  ) u_outReg (
    .clk     (clk),
    .reset   (reset),
    .inValid (accept),
    .inData  (src_data),
    .inUser  (sofBeat),
    .inLast  (lastBeat),
    .inReady (regReady),
    .m       (m_axis)
  );

  // Run end parks in STREAM with the source gated until the
  // output register empties, so IDLE always sees it drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      beat        <= '0;
      line        <= '0;
      frameCnt    <= '0;
      numFrames   <= '0;
      gapLen      <= '0;
      gapCnt      <= '0;
      stopPending <= 1'b0;
      draining    <= 1'b0;
      frameDone   <= 1'b0;
    end else begin
      frameDone <= frameEnd;
      if (state != IDLE && cfg_stop)
        stopPending <= 1'b1;
      unique case (state)
        IDLE: begin
          if (cfg_start) begin
            numFrames <= cfg_num_frames;
            gapLen    <= cfg_gap_cycles;
            frameCnt  <= '0;
            state     <= ARM;
          end
        end
        ARM: state <= STREAM;
        STREAM: begin
          if (draining) begin
            if (regReady) begin
              state       <= IDLE;
              draining    <= 1'b0;
              stopPending <= 1'b0;
            end
          end else if (accept) begin
            if (!lastBeat) begin
              beat <= beat + 1'b1;
            end else begin
              beat <= '0;
              if (!lastLine) begin
                line <= line + 1'b1;
              end else begin
                line     <= '0;
                frameCnt <= frameNext;
                if (stopNow || runDone) begin
                  draining <= 1'b1;
                end else if (gapLen != '0) begin
                  state  <= GAP;
                  gapCnt <= gapLen;
                end else begin
                  state <= ARM;
                end
              end
            end
          end
        end
        GAP: begin
          if (stopNow) begin
            if (regReady) begin
              state       <= IDLE;
              stopPending <= 1'b0;
            end
          end else if (gapCnt <= GAP_W'(1)) begin
            state <= ARM;
          end else begin
            gapCnt <= gapCnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FRAME_SCHED_STATS_EN
  logic [31:0] statFrames;
  logic [31:0] statStalls;

  always_ff @(posedge clk) begin
    if (reset) begin
      statFrames <= '0;
      statStalls <= '0;
    end else begin
      if (frameDone && statFrames != '1)
        statFrames <= statFrames + 1'b1;
      if (m_axis.tvalid && !m_axis.tready && statStalls != '1)
        statStalls <= statStalls + 1'b1;
    end
  end

  assign stat_frames = statFrames;
  assign stat_stalls = statStalls;
`else
  assign stat_frames = '0;
  assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_frame_stream_scheduler.sv
// tb_frame_stream_scheduler: directed runs on a 4x2x3 frame with a
// source-side scoreboard checked against the output stream.
module tb_frame_stream_scheduler;

  localparam int BPL = 12;
  localparam int BPF = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_start;
  logic        cfg_stop;
  logic [15:0] cfg_num_frames;
  logic [15:0] cfg_gap_cycles;
  logic [7:0]  src_data;
  logic        src_valid;
  logic        src_ready;
  logic        src_restart;
  logic        busy;
  logic        frame_done;
  logic [31:0] stat_frames;
  logic [31:0] stat_stalls;

  always #5 clk = ~clk;

  frame_stream_scheduler_if #(.DW(8)) m_axis ();

  frame_stream_scheduler #(
    .WIDTH      (4),
    .HEIGHT     (2),
    .NUMPLANES  (3),
    .DATA_BYTES (1),
    .FRAMES_W   (16),
    .GAP_W      (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_start      (cfg_start),
    .cfg_stop       (cfg_stop),
    .cfg_num_frames (cfg_num_frames),
    .cfg_gap_cycles (cfg_gap_cycles),
    .src_data       (src_data),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .src_restart    (src_restart),
    .m_axis         (m_axis),
    .busy           (busy),
    .frame_done     (frame_done),
    .stat_frames    (stat_frames),
    .stat_stalls    (stat_stalls)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [9:0] sbq[$];
  logic [9:0] expBeat;
  logic [9:0] heldVal;
  logic       holdValid = 1'b0;
  logic       pendingAccept = 1'b0;
  int k = 0;
  int runBeats = 0;
  int outBeats = 0;
  int restarts = 0;
  int dones = 0;
  int cyc = 0;
  int lastAcceptCyc = 0;
  int restartCyc = -10;
  int boundaryIdle = -1;
  int boundaryRestart = 0;
  int readyMode = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Source/sink monitor: inputs only change #1 after posedge.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      holdValid = 1'b0;
    end else begin
      if (src_restart) begin
        restarts++;
        restartCyc = cyc;
      end
      if (frame_done) dones++;
      if (src_valid && src_ready) begin
        sbq.push_back({src_data, k == 0, (k % BPL) == BPL - 1});
        if (k == 0 && runBeats > 0) begin
          boundaryIdle = cyc - lastAcceptCyc - 1;
          boundaryRestart = (restartCyc == cyc - 1) ? 1 : 0;
        end
        lastAcceptCyc = cyc;
        k = (k + 1) % BPF;
        runBeats++;
        pendingAccept = 1'b1;
      end
      if (holdValid)
        check("hold", {m_axis.tvalid, m_axis.tdata,
                       m_axis.tuser, m_axis.tlast},
              {1'b1, heldVal});
      if (m_axis.tvalid && m_axis.tready) begin
        check("beat queue", 32'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          expBeat = sbq.pop_front();
          check("beat", {m_axis.tdata, m_axis.tuser, m_axis.tlast},
                expBeat);
        end
        outBeats++;
      end
      holdValid = m_axis.tvalid && !m_axis.tready;
      heldVal = {m_axis.tdata, m_axis.tuser, m_axis.tlast};
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    cfg_stop = 1'b0;
    if (pendingAccept) begin
      src_data = src_data + 8'd1;
      pendingAccept = 1'b0;
    end
    case (readyMode)
      1: begin
        m_axis.tready = 1'($urandom_range(0, 1));
        src_valid = 1'($urandom_range(0, 1));
      end
      2: begin
        m_axis.tready = 1'b0;
        src_valid = 1'b1;
      end
      default: begin
        m_axis.tready = 1'b1;
        src_valid = 1'b1;
      end
    endcase
  endtask

  task automatic startRun(int nf, int gap);
    cfg_num_frames = 16'(nf);
    cfg_gap_cycles = 16'(gap);
    k = 0;
    runBeats = 0;
    outBeats = 0;
    restarts = 0;
    dones = 0;
    boundaryIdle = -1;
    boundaryRestart = 0;
    cfg_start = 1'b1;
    cycle();
    cfg_num_frames = 16'd7;
    cfg_gap_cycles = 16'd9;
  endtask

  task automatic waitIdle(string tag, int maxCyc);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (busy && n < maxCyc);
    check(tag, 32'(busy), 0);
  endtask

  task automatic waitBeats(string tag, int nb, int maxCyc);
    int n = 0;
    while (runBeats < nb && n < maxCyc) begin
      cycle();
      n++;
    end
    check(tag, 32'(runBeats >= nb), 1);
  endtask

  initial begin
    reset = 1'b1;
    cfg_start = 1'b0;
    cfg_stop = 1'b0;
    cfg_num_frames = '0;
    cfg_gap_cycles = '0;
    src_data = 8'h40;
    src_valid = 1'b1;
    m_axis.tready = 1'b1;
    repeat (3) cycle();

    check("rst tvalid", 32'(m_axis.tvalid), 0);
    check("rst busy", 32'(busy), 0);
    check("rst src_ready", 32'(src_ready), 0);
    check("rst src_restart", 32'(src_restart), 0);
    check("rst frame_done", 32'(frame_done), 0);
    check("rst payload", {m_axis.tdata, m_axis.tuser, m_axis.tlast}, 0);
    check("rst stat_frames", stat_frames, 0);
    check("rst stat_stalls", stat_stalls, 0);
    reset = 1'b0;
    cycle();

    // Two back-to-back frames, no gap.
    startRun(2, 0);
    waitIdle("s1 idle", 300);
    check("s1 beats", outBeats, 48);
    check("s1 restarts", restarts, 2);
    check("s1 frame_done", dones, 2);
    check("s1 idle gap", boundaryIdle, 1);
    check("s1 queue empty", sbq.size(), 0);

    // Inter-frame gap of 5 cycles.
    startRun(2, 5);
    waitIdle("s2 idle", 300);
    check("s2 beats", outBeats, 48);
    check("s2 idle gap", boundaryIdle, 6);
    check("s2 restart last", boundaryRestart, 1);
    check("s2 restarts", restarts, 2);

    // Random backpressure and source valid.
    readyMode = 1;
    startRun(2, 2);
    waitIdle("s3 idle", 2000);
    readyMode = 0;
    cycle();
    check("s3 beats", outBeats, 48);
    check("s3 frame_done", dones, 2);
    check("s3 queue empty", sbq.size(), 0);

    // Continuous run stopped during frame 2.
    startRun(0, 0);
    waitBeats("s4 reach 30", 30, 300);
    cfg_stop = 1'b1;
    cycle();
    waitIdle("s4 idle", 300);
    repeat (10) cycle();
    check("s4 beats", outBeats, 48);
    check("s4 frame_done", dones, 2);
    check("s4 restarts", restarts, 2);
    check("s4 busy", 32'(busy), 0);

    // Reset in mid-frame.
    startRun(1, 0);
    waitBeats("s5 reach 10", 10, 300);
    reset = 1'b1;
    cycle();
    check("s5 tvalid", 32'(m_axis.tvalid), 0);
    check("s5 busy", 32'(busy), 0);
    reset = 1'b0;
    sbq.delete();
    cycle();
    startRun(1, 0);
    waitIdle("s5 idle", 300);
    check("s5 beats", outBeats, 24);
    check("s5 queue empty", sbq.size(), 0);

    // Stall window and frame statistics from a clean reset.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    startRun(3, 0);
    waitBeats("s6 reach 5", 5, 300);
    readyMode = 2;
    m_axis.tready = 1'b0;
    repeat (6) cycle();
    readyMode = 0;
    cycle();
    waitIdle("s6 idle", 400);
    check("s6 beats", outBeats, 72);
    check("s6 frame_done", dones, 3);
`ifdef FRAME_SCHED_STATS_EN
    check("s6 stat_stalls", stat_stalls, 7);
    check("s6 stat_frames", stat_frames, 3);
`else
    check("s6 stat_stalls", stat_stalls, 0);
    check("s6 stat_frames", stat_frames, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
